// File: rtl/icu14500_pkg.sv
// Shared opcode, state and width definitions for the 14500 fetch/decode sequencer.
package icu14500_pkg;

    localparam int unsigned ICU_ADDR_W = 16;

    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_LDC  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDC = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ORC  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_IEN  = 4'hA;
    localparam logic [3:0] OP_OEN  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StJmpHi,
        StJmpLo,
        StLoad,
        StSettle,
        StHalt
    } icu_state_e;

endpackage

// File: rtl/icu_fetch_port.sv
// ROM req/ack handshake with a per-fetch timeout; one fetch per start pulse.
module icu_fetch_port
    import icu14500_pkg::*;
#(
    parameter int unsigned ADDR_W  = ICU_ADDR_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              done,
    output logic              err,
    output logic [7:0]        data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data
);

    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;

    always_comb begin
        req_d  = req_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        done   = 1'b0;
        err    = 1'b0;
        if (req_q) begin
            // An ack in the final allowed cycle still counts as a successful fetch.
            if (mem_ack) begin
                done  = 1'b1;
                req_d = 1'b0;
            end else if (cnt_q + 16'd1 == TimeoutCnt) begin
                err   = 1'b1;
                req_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        // A start in the completion cycle chains straight into the next fetch.
        if (start) begin
            req_d  = 1'b1;
            addr_d = start_addr;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q  <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            req_q  <= req_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign data     = mem_data;

endmodule

// File: rtl/icu_fetch_decode.sv
// Fetch/decode sequencer for the 14500 opcode set: steps the PC, handles JMP/RTN/SKZ.
module icu_fetch_decode
    import icu14500_pkg::*;
#(
    parameter int unsigned ADDR_W    = ICU_ADDR_W,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned RTN_SKIPS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_adv,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    input  logic              rr_in,
    input  logic              exec_ready,
    output logic              instr_valid,
    output logic [3:0]        opcode,
    output logic [3:0]        io_addr,
    output logic              flg0,
    output logic              flgf,
    output logic              jmp_flag,
    output logic              rtn_flag,
    output logic              fetch_err
);

    icu_state_e        state_q, state_d;
    logic              skip_q, skip_d;
    logic [7:0]        instr_q, instr_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              err_q, err_d;

    logic              fp_start;
    logic [ADDR_W-1:0] fp_addr;
    logic              fp_done;
    logic              fp_err;
    logic [7:0]        fp_data;

    icu_fetch_port #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_fetch_port (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (fp_start),
        .start_addr (fp_addr),
        .done       (fp_done),
        .err        (fp_err),
        .data       (fp_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data)
    );

    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        instr_d     = instr_q;
        target_d    = target_q;
        err_d       = err_q;
        fp_start    = 1'b0;
        fp_addr     = pc_addr;
        pc_load     = 1'b0;
        instr_valid = 1'b0;
        flg0        = 1'b0;
        flgf        = 1'b0;
        jmp_flag    = 1'b0;
        rtn_flag    = 1'b0;

        case (state_q)
            StIdle: begin
                fp_start = 1'b1;
                state_d  = StFetch;
            end
            StFetch: begin
                if (fp_done) begin
                    instr_d = fp_data;
                    state_d = StDecode;
                end else if (fp_err) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end
            end
            StDecode: begin
                if (skip_q) begin
                    skip_d   = 1'b0;
                    fp_start = 1'b1;
                    state_d  = StFetch;
                end else begin
                    state_d = StIssue;
                    case (instr_q[7:4])
                        OP_JMP: begin
                            jmp_flag = 1'b1;
                            fp_start = 1'b1;
                            state_d  = StJmpHi;
                        end
                        OP_RTN: begin
                            rtn_flag = 1'b1;
                            skip_d   = (RTN_SKIPS != 0);
                        end
                        OP_SKZ:  skip_d = ~rr_in;
                        OP_NOPO: flg0   = 1'b1;
                        OP_NOPF: flgf   = 1'b1;
                        default: ;
                    endcase
                end
            end
            StIssue: begin
                instr_valid = 1'b1;
                if (exec_ready) begin
                    fp_start = 1'b1;
                    state_d  = StFetch;
                end
            end
            StJmpHi: begin
                if (fp_done) begin
                    target_d[ADDR_W-1 -: 8] = fp_data;
                    fp_start = 1'b1;
                    // The PC only advances at the end of this cycle, so address its next value.
                    fp_addr  = mem_addr + ADDR_W'(1);
                    state_d  = StJmpLo;
                end else if (fp_err) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end
            end
            StJmpLo: begin
                if (fp_done) begin
                    target_d[7:0] = fp_data;
                    state_d       = StLoad;
                end else if (fp_err) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end
            end
            StLoad: begin
                pc_load = 1'b1;
                state_d = StSettle;
            end
            StSettle: begin
                fp_start = 1'b1;
                state_d  = StFetch;
            end
            StHalt: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            skip_q   <= 1'b0;
            instr_q  <= '0;
            target_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            instr_q  <= instr_d;
            target_q <= target_d;
            err_q    <= err_d;
        end
    end

    assign pc_adv       = fp_done;
    assign pc_load_addr = pc_load ? target_q : '0;
    assign opcode       = instr_q[7:4];
    assign io_addr      = instr_q[3:0];
    assign fetch_err    = err_q;

endmodule

// File: tb/tb_icu_fetch_decode.sv
// Scoreboard bench for icu_fetch_decode with a ROM responder and a program-counter model.
module tb_icu_fetch_decode;

    localparam int unsigned ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_adv, pc_load;
    logic [ADDR_W-1:0] pc_load_addr, mem_addr;
    logic              mem_req, mem_ack;
    logic [7:0]        mem_data;
    logic              rr_in, exec_ready;
    logic              instr_valid;
    logic [3:0]        opcode, io_addr;
    logic              flg0, flgf, jmp_flag, rtn_flag, fetch_err;

    always #5 clk = ~clk;

    icu_fetch_decode #(
        .ADDR_W    (ADDR_W),
        .TIMEOUT   (4),
        .RTN_SKIPS (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc_addr      (pc_addr),
        .pc_adv       (pc_adv),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .mem_addr     (mem_addr),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .rr_in        (rr_in),
        .exec_ready   (exec_ready),
        .instr_valid  (instr_valid),
        .opcode       (opcode),
        .io_addr      (io_addr),
        .flg0         (flg0),
        .flgf         (flgf),
        .jmp_flag     (jmp_flag),
        .rtn_flag     (rtn_flag),
        .fetch_err    (fetch_err)
    );

    // ROM: acks only programmed locations, after ack_lat wait cycles.
    logic [7:0]  rom   [0:65535];
    logic        rom_v [0:65535];
    int unsigned ack_lat = 0;
    int unsigned lat_cnt = 0;

    assign mem_data = rom[mem_addr];
    assign mem_ack  = mem_req && rom_v[mem_addr] && (lat_cnt == ack_lat);
    always @(posedge clk) lat_cnt <= (mem_req && !mem_ack) ? lat_cnt + 1 : 0;

    // Program counter model, independent of the DUT reset.
    logic [15:0] pc = 16'd0;
    logic        pc_clr;
    always @(posedge clk) begin
        if (pc_clr)       pc <= 16'd0;
        else if (pc_load) pc <= pc_load_addr;
        else if (pc_adv)  pc <= pc + 16'd1;
    end
    assign pc_addr = pc;

    logic [7:0]  exp_iss[$];
    logic [15:0] exp_fetch[$];
    logic [15:0] exp_load[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_adv = 0, n_load = 0, n_jmp = 0, n_rtn = 0, n_f0 = 0, n_ff = 0;
    int n_both = 0, n_stall = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({pc_adv, pc_load, pc_load_addr, mem_addr, mem_req, instr_valid, opcode,
                    io_addr, flg0, flgf, jmp_flag, rtn_flag, fetch_err});
    endfunction

    // Monitor: pops and compares whenever the DUT presents a fetch, issue or load.
    logic       stall_q = 1'b0;
    logic [7:0] stall_instr = 8'd0;
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_q = 1'b0;
        end else begin
            if (pc_adv)             n_adv++;
            if (pc_load)            n_load++;
            if (jmp_flag)           n_jmp++;
            if (rtn_flag)           n_rtn++;
            if (flg0)               n_f0++;
            if (flgf)               n_ff++;
            if (pc_adv && pc_load)  n_both++;
            if (stall_q) check("issue_hold", 64'({instr_valid, opcode, io_addr}),
                               64'({1'b1, stall_instr}));
            if (instr_valid && !exec_ready) begin
                n_stall++;
                check("no_req_while_stalled", 64'(mem_req), 64'(0));
            end
            if (mem_req && mem_ack) begin
                if (exp_fetch.size() == 0) check("unexpected_fetch", 64'(mem_addr), 64'hFFFF_FFFF);
                else check("fetch_addr", 64'(mem_addr), 64'(exp_fetch.pop_front()));
            end
            if (instr_valid && exec_ready) begin
                if (exp_iss.size() == 0) check("unexpected_issue", 64'({opcode, io_addr}), 64'hFFFF);
                else check("issue", 64'({opcode, io_addr}), 64'(exp_iss.pop_front()));
            end
            if (pc_load) begin
                if (exp_load.size() == 0) check("unexpected_load", 64'(pc_load_addr), 64'hFFFF_FFFF);
                else check("load_addr", 64'(pc_load_addr), 64'(exp_load.pop_front()));
            end
            stall_q     = instr_valid && !exec_ready;
            stall_instr = {opcode, io_addr};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 65536; i++) begin
            rom[i]   = 8'h00;
            rom_v[i] = 1'b0;
        end
        exp_iss.delete();
        exp_fetch.delete();
        exp_load.delete();
    endtask

    task automatic put(input int addr, input logic [7:0] val);
        rom[addr]   = val;
        rom_v[addr] = 1'b1;
    endtask

    // Asserted at posedge+1; outputs must be zero without waiting for a clock.
    task automatic do_reset(input string name, input logic clr_pc);
        reset_n = 1'b0;
        pc_clr  = clr_pc;
        #1;
        check(name, out_vec(), 64'd0);
        tick(2);
        pc_clr = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_iss.size() + exp_fetch.size() + exp_load.size()) != 0 && n < 300) begin
            tick(1);
            n++;
        end
        check(name, 64'(exp_iss.size() + exp_fetch.size() + exp_load.size()), 64'd0);
        tick(3);
    endtask

    int adv0, load0, jmp0, rtn0, f00, ff0, stall0;
    task automatic snap();
        adv0 = n_adv; load0 = n_load; jmp0 = n_jmp; rtn0 = n_rtn;
        f00 = n_f0; ff0 = n_ff; stall0 = n_stall;
    endtask

    initial begin
        reset_n    = 1'b0;
        pc_clr     = 1'b1;
        rr_in      = 1'b0;
        exec_ready = 1'b1;
        tick(1);

        // Straight-line fetch, ack latency 0.
        clear_rom();
        put(0, 8'h10); put(1, 8'h35);
        ack_lat = 0;
        do_reset("reset_state", 1'b1);
        exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001);
        exp_iss.push_back(8'h10); exp_iss.push_back(8'h35);
        snap();
        reset_n = 1'b1;
        wait_drain("straight_drain");
        check("straight_pc_adv", 64'(n_adv - adv0), 64'd2);

        // SKZ with rr_in=0: the word after SKZ is fetched but not issued.
        clear_rom();
        put(0, 8'hE0); put(1, 8'h12); put(2, 8'h83);
        rr_in = 1'b0;
        do_reset("reset_skz0", 1'b1);
        exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001);
        exp_fetch.push_back(16'h0002);
        exp_iss.push_back(8'hE0); exp_iss.push_back(8'h83);
        snap();
        reset_n = 1'b1;
        wait_drain("skz0_drain");
        check("skz0_pc_adv", 64'(n_adv - adv0), 64'd3);

        // SKZ with rr_in=1: no skip.
        rr_in = 1'b1;
        do_reset("reset_skz1", 1'b1);
        exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001);
        exp_fetch.push_back(16'h0002);
        exp_iss.push_back(8'hE0); exp_iss.push_back(8'h12); exp_iss.push_back(8'h83);
        reset_n = 1'b1;
        wait_drain("skz1_drain");
        rr_in = 1'b0;

        // JMP at 0x0004 to 0x1234, ack latency 1.
        clear_rom();
        put(0, 8'hA1); put(1, 8'hB2); put(2, 8'h50); put(3, 8'h61);
        put(4, 8'hC0); put(5, 8'h12); put(6, 8'h34); put(16'h1234, 8'h97);
        ack_lat = 1;
        do_reset("reset_jmp", 1'b1);
        for (int i = 0; i < 7; i++) exp_fetch.push_back(16'(i));
        exp_fetch.push_back(16'h1234);
        exp_iss.push_back(8'hA1); exp_iss.push_back(8'hB2); exp_iss.push_back(8'h50);
        exp_iss.push_back(8'h61); exp_iss.push_back(8'h97);
        exp_load.push_back(16'h1234);
        snap();
        reset_n = 1'b1;
        wait_drain("jmp_drain");
        check("jmp_flag_count", 64'(n_jmp - jmp0), 64'd1);
        check("jmp_load_cycles", 64'(n_load - load0), 64'd1);
        check("jmp_pc_adv", 64'(n_adv - adv0), 64'd8);
        ack_lat = 0;

        // Flag strobes and RTN skip.
        clear_rom();
        put(0, 8'h0A); put(1, 8'hF5); put(2, 8'hD0); put(3, 8'h11); put(4, 8'h22);
        do_reset("reset_flags", 1'b1);
        for (int i = 0; i < 5; i++) exp_fetch.push_back(16'(i));
        exp_iss.push_back(8'h0A); exp_iss.push_back(8'hF5); exp_iss.push_back(8'hD0);
        exp_iss.push_back(8'h22);
        snap();
        reset_n = 1'b1;
        wait_drain("flags_drain");
        check("flg0_count", 64'(n_f0 - f00), 64'd1);
        check("flgf_count", 64'(n_ff - ff0), 64'd1);
        check("rtn_count", 64'(n_rtn - rtn0), 64'd1);

        // Backpressure: exec_ready low for 5 cycles once the first issue appears.
        clear_rom();
        put(0, 8'h35); put(1, 8'h47);
        exec_ready = 1'b0;
        do_reset("reset_bp", 1'b1);
        exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001);
        exp_iss.push_back(8'h35); exp_iss.push_back(8'h47);
        snap();
        reset_n = 1'b1;
        begin
            int n = 0;
            while (!instr_valid && n < 50) begin
                tick(1);
                n++;
            end
            check("bp_valid_seen", 64'(instr_valid), 64'd1);
        end
        tick(5);
        exec_ready = 1'b1;
        wait_drain("bp_drain");
        check("bp_stall_cycles", 64'(n_stall - stall0), 64'd5);

        // Timeout: nothing acks; TIMEOUT=4.
        clear_rom();
        do_reset("reset_timeout", 1'b1);
        snap();
        reset_n = 1'b1;
        begin
            int req_cycles = 0;
            int n = 0;
            int busy = 0;
            while (!fetch_err && n < 50) begin
                @(negedge clk);
                if (!fetch_err && mem_req) req_cycles++;
                n++;
            end
            check("timeout_req_cycles", 64'(req_cycles), 64'd4);
            check("timeout_err", 64'(fetch_err), 64'd1);
            check("timeout_req_low", 64'(mem_req), 64'd0);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (mem_req || pc_adv || pc_load || instr_valid) busy++;
            end
            check("halt_quiet", 64'(busy), 64'd0);
            check("halt_err_sticky", 64'(fetch_err), 64'd1);
            check("halt_pc_adv", 64'(n_adv - adv0), 64'd0);
        end
        tick(1);

        // Reset during JMP_LO: fetch resumes at the PC, no load.
        clear_rom();
        put(0, 8'hC0); put(1, 8'h12); put(2, 8'h34);
        ack_lat = 2;
        do_reset("reset_midjmp_pre", 1'b1);
        exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001);
        snap();
        reset_n = 1'b1;
        begin
            int n = 0;
            while (!(mem_req && mem_addr == 16'h0002) && n < 100) begin
                tick(1);
                n++;
            end
            check("midjmp_reached_lo", 64'({mem_req, mem_addr}), 64'h1_0002);
        end
        do_reset("reset_mid_jmp", 1'b0);
        check("midjmp_pre_fetches", 64'(exp_fetch.size()), 64'd0);
        check("midjmp_jmp_flag", 64'(n_jmp - jmp0), 64'd1);
        exp_fetch.push_back(16'h0002);
        exp_iss.push_back(8'h34);
        reset_n = 1'b1;
        wait_drain("midjmp_drain");
        check("midjmp_no_load", 64'(n_load - load0), 64'd0);

        check("adv_load_overlap", 64'(n_both), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/icu_fetch_decode.md
Name: icu_fetch_decode

Overview:
- Instruction fetch and decode sequencer that sits directly downstream of program_counter.
- Reads the PC address, fetches 8-bit instruction words from program ROM over a req/ack handshake, and steps the PC.
- Decodes the 14500 opcode set for the logic unit and drives the PC load path on JMP.
- Handles the SKZ and RTN skip semantics and the external flag strobes.

Parameters:
- ADDR_W, 16, program address width; must equal the PC width (JMP target is built from two bytes).
- TIMEOUT, 255, maximum cycles to wait for mem_ack before a fetch error; range 1..65535.
- RTN_SKIPS, 1, when 1 RTN also skips the next instruction (MC14500 behaviour); when 0 no skip.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pc_addr  in  ADDR_W  current PC value (program_counter addr_out)
- pc_adv  out  1  one-cycle strobe; PC increments
- pc_load  out  1  one-cycle strobe; drives PC addr_w
- pc_load_addr  out  ADDR_W  jump target; drives PC addr_in
- mem_addr  out  ADDR_W  ROM address, held stable while mem_req=1
- mem_req  out  1  fetch request
- mem_ack  in  1  ROM data valid this cycle
- mem_data  in  8  {opcode[7:4], operand[3:0]}
- rr_in  in  1  result register from the logic unit, used by SKZ
- exec_ready  in  1  logic unit can accept an instruction
- instr_valid  out  1  decoded instruction presented
- opcode  out  4  decoded opcode
- io_addr  out  4  operand / I/O address field
- flg0, flgf, jmp_flag, rtn_flag  out  1  one-cycle external flag strobes
- fetch_err  out  1  sticky timeout error

Behaviour:
- Reset: all outputs are 0. State = IDLE. Skip flag and timeout counter are cleared. Asserting reset mid-fetch drops mem_req immediately, with no wait for ack.
- IDLE -> FETCH on the first clock after reset release.
- FETCH:
  - mem_req=1 and mem_addr=pc_addr, registered on FETCH entry.
  - On mem_ack: latch mem_data, pulse pc_adv in the same cycle, go to DECODE.
  - A timeout counter increments each FETCH cycle. When it reaches TIMEOUT: fetch_err=1, mem_req=0, state = HALT. HALT is left only by reset.
- DECODE (1 cycle):
  - If the skip flag is set: clear it, issue nothing, go to FETCH.
  - C (JMP): pulse jmp_flag, capture operand, go to JMP_HI.
  - D (RTN): pulse rtn_flag; set skip if RTN_SKIPS=1.
  - E (SKZ): set skip if rr_in==0, sampled this cycle.
  - 0 (NOPO): pulse flg0.
  - F (NOPF): pulse flgf.
  - All opcodes except JMP go to ISSUE.
- ISSUE:
  - instr_valid=1 with opcode and io_addr held until a cycle where exec_ready=1; that cycle is the transfer.
  - Then go to FETCH.
  - Flag strobes fire in DECODE and do not wait for exec_ready.
- JMP_HI / JMP_LO:
  - Each state performs a fetch identical to FETCH, including pc_adv and timeout.
  - Byte 1 becomes target[15:8]; byte 2 becomes target[7:0]. JMP occupies 3 words.
  - Then go to LOAD.
- LOAD: pc_load=1 and pc_load_addr=target for 1 cycle, pc_adv=0. Then go to SETTLE.
- SETTLE (1 cycle) lets the registered PC update. Then go to FETCH.
- pc_adv and pc_load are never asserted in the same cycle.
- A skipped instruction is still fetched and the PC still advances. A skipped JMP is skipped as one word only; its operand bytes are then fetched as instructions.
- mem_ack outside a fetch state is ignored.
- Address wrap: PC 0xFFFF -> 0x0000 is handled by the PC; this block needs no special case.
- Minimum throughput: 3 cycles per non-jump instruction (FETCH with ack 1, DECODE, ISSUE with exec_ready).

Decomposition:
- Package icu14500_pkg: 4-bit opcode localparams (OP_NOPO=0 .. OP_NOPF=15), FSM state enum, ADDR_W default.
- Sub-module icu_fetch_port: mem_req/ack handshake plus timeout counter, with start/done/err/data interface. It is reused by FETCH, JMP_HI and JMP_LO.

Test Plan:
- Reset and straight-line fetch: release reset, ROM 0x10,0x35 with ack latency 0 -> instr_valid with opcode 1/io 0, then 3/io 5; one pc_adv per word; mem_addr 0x0000 then 0x0001.
- SKZ: rr_in=0, ROM 0xE0,0x12,0x83 -> 0x12 not issued, 0x83 issued; repeat with rr_in=1 -> 0x12 issued.
- JMP: ROM at 0x0004 = 0xC0,0x12,0x34 -> jmp_flag pulse, pc_load=1 with pc_load_addr=0x1234 for exactly 1 cycle, next mem_addr=0x1234.
- Backpressure: exec_ready=0 for 5 cycles -> instr_valid and opcode held stable, no new mem_req until transfer.
- Timeout: TIMEOUT=4, mem_ack never asserted -> fetch_err=1 after 4 FETCH cycles, mem_req=0, no further activity until reset_n low.
- Reset mid-JMP: assert reset_n low in JMP_LO -> all outputs 0 immediately; after release, fetch resumes at pc_addr and no pc_load occurs.
